reg_fifo_n: RTL and testbench

- Parametrised register-based FIFO for the PtRing ring-stop buffers.
- Next generation of the two-entry register FIFO: configurable DEPTH and WIDTH, selectable first-word-fall-through (FWFT) or registered-read mode.
- Adds an occupancy count, an almost-full threshold, synchronous flush and sticky overflow/underflow flags.
- Sits between the ring link and local port logic: one instance per direction per ring stop.

---
 rtl/ring_fifo_pkg.sv | 22 ++
 rtl/ring_wrap_ptr.sv | 33 +++
 rtl/reg_fifo_n.sv | 130 +++++++++++++
 tb/tb_reg_fifo_n.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ring_fifo_pkg.sv
// Shared definitions for the PtRing ring-stop FIFOs: width helpers, default
// geometry and the error-flag record also used by the multi-VC FIFO.
package ring_fifo_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w = w + 1;
    if (w == 0) w = 1;
    return w;
  endfunction

  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_PTR_W = clog2_min1(DEF_DEPTH);
  localparam int unsigned DEF_CNT_W = clog2_min1(DEF_DEPTH + 1);

  typedef struct packed {
    logic ovf;
    logic udf;
  } fifo_err_t;

endpackage

// File: rtl/ring_wrap_ptr.sv
// Wrapping index counter 0..DEPTH-1; wraps by explicit compare so DEPTH
// need not be a power of two. Clear has priority over increment.
module ring_wrap_ptr
  import ring_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = clog2_min1(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iInc,
  input  logic          iClr,
  output logic [PW-1:0] oPtr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (iClr)      ptr_d = '0;
    else if (iInc) ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign oPtr = ptr_q;

endmodule

// File: rtl/reg_fifo_n.sv
// Parametrised register FIFO for ring-stop buffers: occupancy count,
// almost-full, synchronous flush, sticky overflow/underflow, FWFT or registered read.
module reg_fifo_n
  import ring_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AFULL_TH = 3,
  parameter int unsigned FWFT     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iWrEn,
  input  logic [WIDTH-1:0]           iWrDat,
  input  logic                       iRdEn,
  input  logic                       iFlush,
  output logic                       oFul,
  output logic                       oEmpty,
  output logic                       oAlmFul,
  output logic [$clog2(DEPTH+1)-1:0] oCnt,
  output logic [DEPTH-1:0]           oDatVld,
  output logic [WIDTH-1:0]           oRdDat,
  output logic                       oRdVld,
  output logic                       oOvf,
  output logic                       oUdf
);

  localparam int unsigned PW = clog2_min1(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_q, cnt_d;
  fifo_err_t        err_q, err_d;
  logic             empty, full, rd_acc, wr_acc, wr_go, rd_go;
  logic [WIDTH-1:0] head;

  always_comb begin
    empty  = (cnt_q == '0);
    full   = (cnt_q == DEPTH_C);
    rd_acc = iRdEn & ~empty;
    // a pop in the same cycle frees the slot a write into a full FIFO needs
    wr_acc = iWrEn & (~full | rd_acc);
    wr_go  = wr_acc & ~iFlush;
    rd_go  = rd_acc & ~iFlush;

    cnt_d = cnt_q;
    if (iFlush)                cnt_d = '0;
    else if (wr_acc & ~rd_acc) cnt_d = cnt_q + CW'(1);
    else if (rd_acc & ~wr_acc) cnt_d = cnt_q - CW'(1);

    err_d = err_q;
    if (iFlush) begin
      err_d = '0;
    end else begin
      if (iWrEn & full & ~rd_acc) err_d.ovf = 1'b1;
      if (iRdEn & empty)          err_d.udf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_ptr] <= iWrDat;
  end

  ring_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .iInc(wr_go),
    .iClr(iFlush),
    .oPtr(wr_ptr)
  );

  ring_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .iInc(rd_go),
    .iClr(iFlush),
    .oPtr(rd_ptr)
  );

  assign head = mem_q[rd_ptr];

  always_comb begin
    oDatVld = '0;
    for (int unsigned k = 0; k < DEPTH; k++) oDatVld[k] = (32'(cnt_q) > k);
  end

  assign oEmpty  = empty;
  assign oFul    = full;
  assign oAlmFul = (32'(cnt_q) >= AFULL_TH);
  assign oCnt    = cnt_q;
  assign oOvf    = err_q.ovf;
  assign oUdf    = err_q.udf;

  generate
    if (FWFT != 0) begin : g_fwft
      // storage is not reset, so the head is masked to zero while empty
      assign oRdDat = empty ? '0 : head;
      assign oRdVld = ~empty;
    end else begin : g_regrd
      logic [WIDTH-1:0] rdat_q;
      logic             rvld_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdat_q <= '0;
          rvld_q <= 1'b0;
        end else begin
          rvld_q <= rd_go;
          if (rd_go) rdat_q <= head;
        end
      end

      assign oRdDat = rdat_q;
      assign oRdVld = rvld_q;
    end
  endgenerate

endmodule

// File: tb/tb_reg_fifo_n.sv
// Bench for reg_fifo_n: FWFT and registered-read instances share stimulus and
// are checked against a queue-based reference model.
module tb_reg_fifo_n;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned TH = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iWrEn = 1'b0, iRdEn = 1'b0, iFlush = 1'b0;
  logic [W-1:0] iWrDat = '0;

  logic         f1_ful, f1_empty, f1_afu, f1_rvld, f1_ovf, f1_udf;
  logic [2:0]   f1_cnt;
  logic [D-1:0] f1_dv;
  logic [W-1:0] f1_rdat;
  logic         f0_ful, f0_empty, f0_afu, f0_rvld, f0_ovf, f0_udf;
  logic [2:0]   f0_cnt;
  logic [D-1:0] f0_dv;
  logic [W-1:0] f0_rdat;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [W-1:0] mq[$];
  bit           m_ovf, m_udf, m_rv0;
  logic [W-1:0] m_rd0;

  always #5 clk = ~clk;

  reg_fifo_n #(.WIDTH(W), .DEPTH(D), .AFULL_TH(TH), .FWFT(1)) u_dut (
    .clk(clk), .rst(rst), .iWrEn(iWrEn), .iWrDat(iWrDat), .iRdEn(iRdEn), .iFlush(iFlush),
    .oFul(f1_ful), .oEmpty(f1_empty), .oAlmFul(f1_afu), .oCnt(f1_cnt), .oDatVld(f1_dv),
    .oRdDat(f1_rdat), .oRdVld(f1_rvld), .oOvf(f1_ovf), .oUdf(f1_udf)
  );

  reg_fifo_n #(.WIDTH(W), .DEPTH(D), .AFULL_TH(TH), .FWFT(0)) u_dut_reg (
    .clk(clk), .rst(rst), .iWrEn(iWrEn), .iWrDat(iWrDat), .iRdEn(iRdEn), .iFlush(iFlush),
    .oFul(f0_ful), .oEmpty(f0_empty), .oAlmFul(f0_afu), .oCnt(f0_cnt), .oDatVld(f0_dv),
    .oRdDat(f0_rdat), .oRdVld(f0_rvld), .oOvf(f0_ovf), .oUdf(f0_udf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned n;
    n = mq.size();
    chk({tag, ".cnt"},    32'(f1_cnt),   n);
    chk({tag, ".empty"},  32'(f1_empty), 32'(n == 0));
    chk({tag, ".ful"},    32'(f1_ful),   32'(n == D));
    chk({tag, ".afull"},  32'(f1_afu),   32'(n >= TH));
    chk({tag, ".datvld"}, 32'(f1_dv),    (32'd1 << n) - 1);
    chk({tag, ".rdat"},   32'(f1_rdat),  (n != 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, ".rvld"},   32'(f1_rvld),  32'(n != 0));
    chk({tag, ".ovf"},    32'(f1_ovf),   32'(m_ovf));
    chk({tag, ".udf"},    32'(f1_udf),   32'(m_udf));
    chk({tag, ".r.cnt"},  32'(f0_cnt),   n);
    chk({tag, ".r.flg"},  32'({f0_ful, f0_empty, f0_afu, f0_ovf, f0_udf}),
        32'({n == D, n == 0, n >= TH, m_ovf, m_udf}));
    chk({tag, ".r.dv"},   32'(f0_dv),    (32'd1 << n) - 1);
    chk({tag, ".r.rdat"}, 32'(f0_rdat),  32'(m_rd0));
    chk({tag, ".r.rvld"}, 32'(f0_rvld),  32'(m_rv0));
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_udf = 0; m_rv0 = 0; m_rd0 = '0;
  endtask

  task automatic model_edge(input bit wr, input logic [W-1:0] wd, input bit rd, input bit fl);
    bit emp, ful, racc, wacc;
    if (fl) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_rv0 = 0;
      return;
    end
    emp  = (mq.size() == 0);
    ful  = (mq.size() == D);
    racc = rd && !emp;
    wacc = wr && (!ful || racc);
    if (rd && emp)          m_udf = 1;
    if (wr && ful && !racc) m_ovf = 1;
    m_rv0 = racc;
    if (racc) m_rd0 = mq.pop_front();
    if (wacc) mq.push_back(wd);
  endtask

  task automatic step(input bit wr, input logic [W-1:0] wd, input bit rd, input bit fl,
                      input string tag);
    @(negedge clk);
    iWrEn = wr; iWrDat = wd; iRdEn = rd; iFlush = fl;
    @(posedge clk);
    model_edge(wr, wd, rd, fl);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    iWrEn = 0; iRdEn = 0; iFlush = 0;
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #1 check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // fill, overflow, drain
    step(1, 8'h11, 0, 0, "t1.w1");
    step(1, 8'h22, 0, 0, "t1.w2");
    step(1, 8'h33, 0, 0, "t1.w3");
    step(1, 8'h44, 0, 0, "t1.w4");
    step(1, 8'h55, 0, 0, "t2.ovf");
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0, "t2.pop");
    async_reset("t2.rst");

    // full with simultaneous write+pop, drain across the wrap
    for (int i = 0; i < 4; i++) step(1, 8'(8'h11 * (i + 1)), 0, 0, "t3.fill");
    step(1, 8'h66, 1, 0, "t3.both");
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0, "t3.pop");

    // underflow, write+read while empty
    step(0, '0, 1, 0, "t4.udf");
    step(1, 8'h77, 1, 0, "t4.wr_rd");
    step(0, '0, 1, 0, "t4.pop");

    // flush beats a concurrent write and clears errors
    for (int i = 0; i < 5; i++) step(1, 8'(8'h80 + i), 0, 0, "t5.fill");
    step(0, '0, 1, 0, "t5.pop");
    step(1, 8'hEE, 0, 1, "t5.flush");
    step(0, '0, 0, 0, "t5.idle");

    // registered-read pulse and mid-burst reset
    step(1, 8'hA5, 0, 0, "t6.w");
    step(0, '0, 1, 0, "t6.pop");
    step(0, '0, 0, 0, "t6.hold");
    step(1, 8'h5A, 0, 0, "t6.w2");
    step(1, 8'h3C, 1, 0, "t6.burst");
    async_reset("t6.rst");
    step(1, 8'hC3, 0, 0, "t6.after");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit wr, rd, fl;
      wr = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 3);
      step(wr, 8'($urandom), rd, fl, "rnd");
      if ($urandom_range(0, 199) == 0) async_reset("rnd.rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
